// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the byte-wide memory port arbiter:
//   - state encoding of the access sequencer (IDLE/LO/HI/WAIT/DONE)
//   - requester identifiers (instruction fetch / load-store)
//   - byte-load extension helper
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam logic [2:0] ST_IDLE_ENC = 3'd0;
    localparam logic [2:0] ST_LO_ENC   = 3'd1;
    localparam logic [2:0] ST_HI_ENC   = 3'd2;
    localparam logic [2:0] ST_WAIT_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_LO   = ST_LO_ENC,
        ST_HI   = ST_HI_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_DONE = ST_DONE_ENC
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Widen a loaded byte to 16 bits; sign bit only replicated when sgn is set.
    function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sgn);
        return {{8{b[7] & sgn}}, b};
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner select between instruction fetch and load/store.
//   Build option MEM_ARB_ROUND_ROBIN_EN:
//     undefined : fixed priority, LS beats IF on a tie
//     defined   : on a tie the requester not granted last time wins
//   A lone requester always wins.
// Ports
//   last_grant  in  1  id of the previous winner (round-robin build only)
//   if_req      in  1  fetch request
//   ls_req      in  1  load/store request
//   grant_valid out 1  at least one requester is asking
//   grant_id    out 1  winning requester (REQ_IF / REQ_LS)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    input  logic if_req,
    input  logic ls_req,
    output logic grant_valid,
    output logic grant_id
);

    // Winner selection; tie policy depends on the build option.
    always_comb begin
        grant_valid = if_req | ls_req;
        grant_id    = REQ_IF;
        if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_grant == REQ_IF) begin
                grant_id = REQ_LS;
            end else begin
                grant_id = REQ_IF;
            end
`else
            grant_id = REQ_LS;
`endif
        end else if (ls_req) begin
            grant_id = REQ_LS;
        end else begin
            grant_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one byte-wide single-port memory between instruction fetch (IF)
//   and load/store (LS). Each 16-bit access is split into two byte cycles,
//   little-endian (low byte at addr, high byte at addr+1, wrapping).
//   Sequences: word read LO,HI,WAIT,DONE; byte read LO,WAIT,DONE;
//              word write LO,HI,DONE; byte write LO,DONE.
//   Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   (last_grant register) instead of fixed LS-over-IF priority.
// Ports
//   clk, reset                 clock / synchronous active-high reset
//   if_req, if_addr            fetch request and byte address
//   if_rdata, if_done          fetched word, one-cycle completion pulse
//   ls_req, ls_we, ls_byte,    load/store request, store, byte access,
//   ls_signed, ls_addr,        byte-load sign extend, address,
//   ls_wdata                   store data
//   ls_rdata, ls_done          load result, one-cycle completion pulse
//   mem_en, mem_we, mem_addr,  memory strobe, write enable, byte address,
//   mem_wdata, mem_rdata       write byte, read byte (1-cycle latency)
//   busy                       high whenever not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic              ls_byte,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [15:0]       ls_wdata,
    output logic [15:0]       ls_rdata,
    output logic              ls_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    arb_state_t        state_r;
    arb_state_t        state_next_s;

    // Latched transaction attributes and their next values.
    logic [ADDR_W-1:0] addr_r,   addr_next_s;
    logic              we_r,     we_next_s;
    logic              byte_r,   byte_next_s;
    logic              signed_r, signed_next_s;
    logic [15:0]       wdata_r,  wdata_next_s;
    logic              owner_r,  owner_next_s;

    logic              grant_valid_s;
    logic              grant_id_s;

    logic [7:0]        lo_byte_r;

    logic              access_next_s;
    logic [ADDR_W-1:0] mem_addr_next_s;
    logic [7:0]        mem_wdata_next_s;

    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              busy_r;
    logic              if_done_r;
    logic              ls_done_r;
    logic [15:0]       if_rdata_r;
    logic [15:0]       ls_rdata_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_r;
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_r),
`endif
        .if_req      (if_req),
        .ls_req      (ls_req),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Next-state logic and capture of the winner's request in IDLE.
    always_comb begin
        state_next_s  = state_r;
        addr_next_s   = addr_r;
        we_next_s     = we_r;
        byte_next_s   = byte_r;
        signed_next_s = signed_r;
        wdata_next_s  = wdata_r;
        owner_next_s  = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = ST_LO;
                    owner_next_s = grant_id_s;
                    if (grant_id_s == REQ_LS) begin
                        addr_next_s   = ls_addr;
                        we_next_s     = ls_we;
                        byte_next_s   = ls_byte;
                        signed_next_s = ls_signed;
                        wdata_next_s  = ls_wdata;
                    end else begin
                        // Fetch is always a word read.
                        addr_next_s   = if_addr;
                        we_next_s     = 1'b0;
                        byte_next_s   = 1'b0;
                        signed_next_s = 1'b0;
                        wdata_next_s  = 16'h0000;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (!byte_r) begin
                    state_next_s = ST_HI;
                end else if (!we_r) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_HI: begin
                if (we_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Memory-side values for the coming cycle, decoded from the next state.
    always_comb begin
        access_next_s    = 1'b0;
        mem_addr_next_s  = {ADDR_W{1'b0}};
        mem_wdata_next_s = 8'h00;
        case (state_next_s)
            ST_LO: begin
                access_next_s    = 1'b1;
                mem_addr_next_s  = addr_next_s;
                mem_wdata_next_s = wdata_next_s[7:0];
            end
            ST_HI: begin
                // Address wraps naturally at the top of the space.
                access_next_s    = 1'b1;
                mem_addr_next_s  = addr_next_s + ADDR_ONE;
                mem_wdata_next_s = wdata_next_s[15:8];
            end
            default: begin
                access_next_s    = 1'b0;
                mem_addr_next_s  = {ADDR_W{1'b0}};
                mem_wdata_next_s = 8'h00;
            end
        endcase
    end

    // State register and latched transaction attributes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            we_r     <= 1'b0;
            byte_r   <= 1'b0;
            signed_r <= 1'b0;
            wdata_r  <= 16'h0000;
            owner_r  <= REQ_IF;
        end else begin
            state_r  <= state_next_s;
            addr_r   <= addr_next_s;
            we_r     <= we_next_s;
            byte_r   <= byte_next_s;
            signed_r <= signed_next_s;
            wdata_r  <= wdata_next_s;
            owner_r  <= owner_next_s;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the most recent winner for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= REQ_IF;
        end else if ((state_r == ST_IDLE) && grant_valid_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Registered control outputs, produced one cycle ahead from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'h00;
            busy_r      <= 1'b0;
            if_done_r   <= 1'b0;
            ls_done_r   <= 1'b0;
        end else begin
            mem_en_r    <= access_next_s;
            mem_we_r    <= access_next_s & we_next_s;
            mem_addr_r  <= mem_addr_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            if_done_r   <= (state_next_s == ST_DONE) && (owner_next_s == REQ_IF);
            ls_done_r   <= (state_next_s == ST_DONE) && (owner_next_s == REQ_LS);
        end
    end

    // Read assembly: low byte arrives during HI, final byte during WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_byte_r  <= 8'h00;
            if_rdata_r <= 16'h0000;
            ls_rdata_r <= 16'h0000;
        end else begin
            if ((state_r == ST_HI) && !we_r) begin
                lo_byte_r <= mem_rdata;
            end else begin
                lo_byte_r <= lo_byte_r;
            end
            if ((state_r == ST_WAIT) && (owner_r == REQ_IF)) begin
                if_rdata_r <= {mem_rdata, lo_byte_r};
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if ((state_r == ST_WAIT) && (owner_r == REQ_LS)) begin
                ls_rdata_r <= byte_r ? extend_byte(mem_rdata, signed_r)
                                     : {mem_rdata, lo_byte_r};
            end else begin
                ls_rdata_r <= ls_rdata_r;
            end
        end
    end

    // Strobe is also blocked during reset so an aborted access never writes.
    assign mem_en    = mem_en_r & ~reset;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign if_done   = if_done_r;
    assign ls_done   = ls_done_r;
    assign if_rdata  = if_rdata_r;
    assign ls_rdata  = ls_rdata_r;

endmodule
